fifo_drain_arbiter: RTL and testbench
=====================================

Name: fifo_drain_arbiter

Overview:
- Shares one AXI-stream egress between two capture FIFO read ports: ch0 = analog-sampler (AS) FIFO, ch1 = logic-analyzer (LA) FIFO.
- Grants one channel at a time for a burst of up to burst_len beats, round-robin between channels, with urgent override.
- Tags each output beat with its source id.
- Sits between the two FIFO read interfaces and the stream uplink.

Parameters:
- WIDTH, 45, data width of each FIFO read port and of m_tdata.
- CNT_W, 16, width of the per-channel beat counters.

Ports:
- axis_clk  in  1  clock.
- axi_reset  in  1  asynchronous, active-high reset.
- enable  in  1  arbitration enable.
- burst_len  in  8  max beats per grant; 0 = unlimited.
- urgent  in  2  per-channel priority request, e.g. ch0 tied to ~w_rdy of the AS FIFO.
- s_vld  in  2  per-channel FIFO r_vld.
- s_rdy  out  2  per-channel FIFO r_rdy.
- s_data0  in  WIDTH  ch0 read data.
- s_data1  in  WIDTH  ch1 read data.
- m_tvalid  out  1  egress valid.
- m_tready  in  1  egress ready.
- m_tdata  out  WIDTH  egress data.
- m_tid  out  1  source channel of the current m_tdata.
- busy  out  1  state != IDLE or m_tvalid.
- beat_cnt0  out  CNT_W  beats accepted from ch0, wraps.
- beat_cnt1  out  CNT_W  beats accepted from ch1, wraps.

Behaviour:
- Reset (async, axi_reset=1):
  - state=IDLE; s_rdy=0; m_tvalid=0; m_tdata=0; m_tid=0.
  - beat counter=0; beat_cnt0/1=0; last_grant=1, so ch0 wins the first tie.
  - Any in-flight beat is discarded; the FIFOs' own reset is separate.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - If enable and any s_vld: choose the channel.
    - Urgent+valid channels win.
    - If both or neither qualify, pick the channel != last_grant.
  - Next state GRANTx; clear beat counter; last_grant<=x.
  - Otherwise stay in IDLE.
- GRANTx:
  - s_rdy[x] = slot_free, where slot_free = ~m_tvalid | m_tready. s_rdy of the other channel = 0.
  - Beat accepted when s_vld[x] & s_rdy[x]:
    - Output register loads s_datax and m_tid=x; m_tvalid=1 next cycle.
    - Beat counter and beat_cntx increment.
  - Exit to IDLE at the end of the cycle when any of the following holds:
    - (a) a beat is accepted and count+1 == burst_len (burst_len != 0);
    - (b) slot_free & ~s_vld[x];
    - (c) slot_free & urgent[~x] & s_vld[~x] & ~urgent[x] — a beat accepted this cycle still completes;
    - (d) ~enable, evaluated only when slot_free.
  - One IDLE bubble cycle between grants is required and accepted.
- Output register:
  - Single stage. m_tvalid clears on m_tready when no new beat loads; holds data stable while m_tvalid & ~m_tready (AXI-stream rule).
  - Latency: source accept at cycle t → m_tvalid at t+1.
  - Throughput: 1 beat/cycle within a burst while m_tready=1.
- No combinational path from m_tready to m_tdata. s_rdy depends combinationally on m_tready; this is acceptable because the FIFO's r_vld does not depend on r_rdy.
- burst_len is sampled live. Changing it mid-burst applies from the next comparison. A value ≤ the current count ends the burst at the next accepted beat.
- Counters wrap 2^CNT_W−1 → 0 without flag.
- FIFO usage constraint: s_rdy never asserts toward a channel without a grant, so no FIFO read pointer advances without a grant.

Decomposition:
- Shared package (fifo_pkg): state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2), channel id constants CH_AS=0, CH_LA=1.
- One sub-module: axis_reg_slice (single-entry valid/ready register, WIDTH+1 bits carrying data and tid).
- Arbitration FSM and counters stay in the top module.

Test Plan:
- Reset then idle: both s_vld=0 → m_tvalid=0, s_rdy=2'b00, busy=0. Assert axi_reset mid-burst → m_tvalid=0 immediately, counters 0.
- Both channels continuously valid, burst_len=4, m_tready=1:
  - Expected: 4 beats ch0 (m_tid=0), one bubble, 4 beats ch1, alternating.
  - beat_cnt0=beat_cnt1=8 after 2 rounds.
- ch1 bursting with burst_len=0; raise urgent[0] with s_vld[0]=1 → ch1 stops within 1 cycle after the current beat, and ch0 is granted next.
- Backpressure: m_tready=0 for 5 cycles mid-burst → m_tdata/m_tid held stable, s_rdy=0, no counter change; data resumes in order with no loss or duplication.
- ch0 drops s_vld after 2 beats of burst_len=8 → grant returns to IDLE and ch1 is served. With enable=0 → no new grant, busy drops once the output drains.
- Counter wrap with CNT_W=4: push 17 beats on ch0 → beat_cnt0=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the two-channel FIFO drain arbiter:
// FSM state encoding and channel identifiers.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic CH_AS = 1'b0;
    localparam logic CH_LA = 1'b1;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry valid/ready register stage; output data never depends
// combinationally on out_ready_i.
module axis_reg_slice #(
    parameter int unsigned W = 46
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o = ~valid_q | out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst arbiter with urgent override draining two capture
// FIFOs into one AXI-stream egress; each beat is tagged with its source.
module fifo_drain_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 45,
    parameter int unsigned CNT_W = 16
) (
    input  logic             axis_clk,
    input  logic             axi_reset,
    input  logic             enable,
    input  logic [7:0]       burst_len,
    input  logic [1:0]       urgent,
    input  logic [1:0]       s_vld,
    output logic [1:0]       s_rdy,
    input  logic [WIDTH-1:0] s_data0,
    input  logic [WIDTH-1:0] s_data1,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tid,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt0,
    output logic [CNT_W-1:0] beat_cnt1
);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] bcnt0_q, bcnt0_d;
    logic [CNT_W-1:0] bcnt1_q, bcnt1_d;

    logic             slot_free;
    logic             acc;
    logic             gch;
    logic             pick;
    logic [1:0]       cand;
    logic             burst_done;
    logic [WIDTH:0]   slice_in;
    logic [WIDTH:0]   slice_out;

    assign gch      = (state_q == GRANT1) ? CH_LA : CH_AS;
    assign slice_in = {gch, (gch == CH_LA) ? s_data1 : s_data0};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        bcnt0_d    = bcnt0_q;
        bcnt1_d    = bcnt1_q;
        s_rdy      = '0;
        acc        = 1'b0;
        pick       = CH_AS;
        cand       = '0;
        burst_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (|s_vld)) begin
                    // Urgent+valid channels take precedence; a lone candidate
                    // wins outright, otherwise alternate against last grant.
                    cand = (|(urgent & s_vld)) ? (urgent & s_vld) : s_vld;
                    if (cand == 2'b01)      pick = CH_AS;
                    else if (cand == 2'b10) pick = CH_LA;
                    else                    pick = ~last_q;
                    state_d = (pick == CH_LA) ? GRANT1 : GRANT0;
                    cnt_d   = '0;
                    last_d  = pick;
                end
            end
            GRANT0, GRANT1: begin
                s_rdy[gch] = slot_free;
                acc        = s_vld[gch] & slot_free;
                if (acc) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    if (gch == CH_LA) bcnt1_d = bcnt1_q + CNT_W'(1);
                    else              bcnt0_d = bcnt0_q + CNT_W'(1);
                end
                burst_done = acc && (burst_len != 8'd0) &&
                             (({1'b0, cnt_q} + 9'd1) >= {1'b0, burst_len});
                if (burst_done ||
                    (slot_free && (~s_vld[gch] ||
                                   (urgent[~gch] & s_vld[~gch] & ~urgent[gch]) ||
                                   ~enable))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= CH_LA;
            bcnt0_q <= '0;
            bcnt1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bcnt0_q <= bcnt0_d;
            bcnt1_q <= bcnt1_d;
        end
    end

    axis_reg_slice #(
        .W (WIDTH + 1)
    ) u_slice (
        .clk_i       (axis_clk),
        .rst_i       (axi_reset),
        .in_valid_i  (acc),
        .in_ready_o  (slot_free),
        .in_data_i   (slice_in),
        .out_valid_o (m_tvalid),
        .out_ready_i (m_tready),
        .out_data_o  (slice_out)
    );

    assign m_tdata   = slice_out[WIDTH-1:0];
    assign m_tid     = slice_out[WIDTH];
    assign busy      = (state_q != IDLE) | m_tvalid;
    assign beat_cnt0 = bcnt0_q;
    assign beat_cnt1 = bcnt1_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Self-checking bench for fifo_drain_arbiter: directed scenarios plus a
// randomized run against a queue-based source/egress reference model.
module tb_fifo_drain_arbiter;

    localparam int unsigned W  = 45;
    localparam int unsigned CW = 4;

    logic          axis_clk = 1'b0;
    logic          axi_reset;
    logic          enable;
    logic [7:0]    burst_len;
    logic [1:0]    urgent;
    logic [1:0]    s_vld;
    logic [1:0]    s_rdy;
    logic [W-1:0]  s_data0, s_data1;
    logic          m_tvalid;
    logic          m_tready;
    logic [W-1:0]  m_tdata;
    logic          m_tid;
    logic          busy;
    logic [CW-1:0] beat_cnt0, beat_cnt1;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] src0[$], src1[$], exp0[$], exp1[$];
    logic [1:0]   vld_en;
    int           mcnt0, mcnt1;

    logic         pend_valid;
    logic [W-1:0] pend_data;
    logic         pend_tid;

    logic [1:0]   obs_srdy;
    logic         obs_valid, obs_tid, obs_busy;
    logic [W-1:0] obs_data;

    always #5 axis_clk = ~axis_clk;

    fifo_drain_arbiter #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .axis_clk  (axis_clk),
        .axi_reset (axi_reset),
        .enable    (enable),
        .burst_len (burst_len),
        .urgent    (urgent),
        .s_vld     (s_vld),
        .s_rdy     (s_rdy),
        .s_data0   (s_data0),
        .s_data1   (s_data1),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tid     (m_tid),
        .busy      (busy),
        .beat_cnt0 (beat_cnt0),
        .beat_cnt1 (beat_cnt1)
    );

    task automatic drive_src();
        s_vld[0] = vld_en[0] && (src0.size() > 0);
        s_vld[1] = vld_en[1] && (src1.size() > 0);
        s_data0  = (src0.size() > 0) ? src0[0] : '0;
        s_data1  = (src1.size() > 0) ? src1[0] : '0;
    endtask

    task automatic fill(input int ch, input int n);
        logic [W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = {13'($urandom), 32'($urandom)};
            if (ch == 0) src0.push_back(d);
            else         src1.push_back(d);
        end
    endtask

    // One clock cycle: sample at negedge, model handshakes, advance at posedge.
    task automatic tick();
        logic a0, a1;
        logic [W-1:0] e;
        drive_src();
        @(negedge axis_clk);
        obs_srdy  = s_rdy;
        obs_valid = m_tvalid;
        obs_tid   = m_tid;
        obs_data  = m_tdata;
        obs_busy  = busy;
        tests++;
        if (s_rdy === 2'b11) begin
            fails++;
            $display("FAIL rdy_exclusive: s_rdy=%b required one-hot or zero", s_rdy);
        end
        if (pend_valid) begin
            tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== pend_data || m_tid !== pend_tid) begin
                fails++;
                $display("FAIL latency: got v=%b d=%h id=%b required v=1 d=%h id=%b",
                         m_tvalid, m_tdata, m_tid, pend_data, pend_tid);
            end
        end
        pend_valid = 1'b0;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            tests++;
            if (m_tid === 1'b0 && exp0.size() > 0) begin
                e = exp0.pop_front();
                if (m_tdata !== e) begin
                    fails++;
                    $display("FAIL order_ch0: got %h required %h", m_tdata, e);
                end
            end else if (m_tid === 1'b1 && exp1.size() > 0) begin
                e = exp1.pop_front();
                if (m_tdata !== e) begin
                    fails++;
                    $display("FAIL order_ch1: got %h required %h", m_tdata, e);
                end
            end else begin
                fails++;
                $display("FAIL spurious_beat: id=%b d=%h with no pending source beat", m_tid, m_tdata);
            end
        end
        a0 = (s_vld[0] === 1'b1) && (s_rdy[0] === 1'b1);
        a1 = (s_vld[1] === 1'b1) && (s_rdy[1] === 1'b1);
        if (a0) begin
            pend_valid = 1'b1; pend_data = s_data0; pend_tid = 1'b0;
            exp0.push_back(s_data0); mcnt0++;
        end
        if (a1) begin
            pend_valid = 1'b1; pend_data = s_data1; pend_tid = 1'b1;
            exp1.push_back(s_data1); mcnt1++;
        end
        @(posedge axis_clk);
        #1;
        if (a0) void'(src0.pop_front());
        if (a1) void'(src1.pop_front());
        drive_src();
    endtask

    task automatic do_reset();
        axi_reset = 1'b1;
        enable    = 1'b1;
        burst_len = 8'd0;
        urgent    = 2'b00;
        m_tready  = 1'b1;
        vld_en    = 2'b00;
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
        mcnt0 = 0; mcnt1 = 0;
        pend_valid = 1'b0;
        drive_src();
        repeat (2) @(posedge axis_clk);
        #1;
        axi_reset = 1'b0;
    endtask

    task automatic wait_grant(input logic [1:0] want, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (obs_srdy === want) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: s_rdy=%b never reached required %b", name, obs_srdy, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge axis_clk);
        tests++;
        if (m_tvalid !== 1'b0 || s_rdy !== 2'b00 || busy !== 1'b0 || m_tdata !== '0 ||
            m_tid !== 1'b0 || beat_cnt0 !== '0 || beat_cnt1 !== '0) begin
            fails++;
            $display("FAIL reset_idle: v=%b rdy=%b busy=%b d=%h id=%b c0=%0d c1=%0d required all zero",
                     m_tvalid, s_rdy, busy, m_tdata, m_tid, beat_cnt0, beat_cnt1);
        end
        @(posedge axis_clk); #1;
        fill(0, 10);
        vld_en = 2'b01;
        repeat (4) tick();
        axi_reset = 1'b1;
        #1;
        tests++;
        if (m_tvalid !== 1'b0 || beat_cnt0 !== '0 || s_rdy !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_midburst: v=%b c0=%0d rdy=%b busy=%b required 0/0/00/0",
                     m_tvalid, beat_cnt0, s_rdy, busy);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int  p;
        bit  ev;
        logic et;
        do_reset();
        burst_len = 8'd4;
        fill(0, 20); fill(1, 20);
        vld_en = 2'b11;
        for (int k = 0; k < 21; k++) begin
            tick();
            ev = 1'b0; et = 1'b0;
            if (k > 0) begin
                p  = (k - 1) % 10;
                ev = (p != 0) && (p != 5);
                et = (p > 5);
            end
            tests++;
            if (obs_valid !== ev || (ev && obs_tid !== et)) begin
                fails++;
                $display("FAIL rr_cycle%0d: got v=%b id=%b required v=%b id=%b",
                         k, obs_valid, obs_tid, ev, et);
            end
        end
        tests++;
        if (beat_cnt0 !== 4'd8 || beat_cnt1 !== 4'd8) begin
            fails++;
            $display("FAIL rr_counts: got %0d/%0d required 8/8", beat_cnt0, beat_cnt1);
        end
        vld_en = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_urgent();
        do_reset();
        burst_len = 8'd0;
        fill(0, 20); fill(1, 20);
        vld_en = 2'b10;
        wait_grant(2'b10, "urg_ch1_grant");
        repeat (2) tick();
        vld_en = 2'b11;
        urgent = 2'b01;
        tick();
        tests++;
        if (obs_srdy !== 2'b10) begin
            fails++;
            $display("FAIL urg_last_beat: s_rdy=%b required 10", obs_srdy);
        end
        tick();
        tests++;
        if (obs_srdy !== 2'b00) begin
            fails++;
            $display("FAIL urg_bubble: s_rdy=%b required 00", obs_srdy);
        end
        tick();
        tests++;
        if (obs_srdy !== 2'b01) begin
            fails++;
            $display("FAIL urg_ch0_grant: s_rdy=%b required 01", obs_srdy);
        end
        urgent = 2'b00;
        tick();
        tests++;
        if (obs_valid !== 1'b1 || obs_tid !== 1'b0) begin
            fails++;
            $display("FAIL urg_tid: v=%b id=%b required v=1 id=0", obs_valid, obs_tid);
        end
        vld_en = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] held;
        int           cnt;
        do_reset();
        burst_len = 8'd8;
        fill(0, 20);
        vld_en = 2'b01;
        wait_grant(2'b01, "bp_grant");
        tick();
        m_tready = 1'b0;
        held = exp0[0];
        cnt  = mcnt0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (obs_valid !== 1'b1 || obs_data !== held || obs_tid !== 1'b0 ||
                obs_srdy !== 2'b00 || beat_cnt0 !== CW'(cnt)) begin
                fails++;
                $display("FAIL bp_hold%0d: v=%b d=%h id=%b rdy=%b c0=%0d required 1/%h/0/00/%0d",
                         i, obs_valid, obs_data, obs_tid, obs_srdy, beat_cnt0, held, cnt);
            end
        end
        m_tready = 1'b1;
        repeat (12) tick();
        vld_en = 2'b00;
        repeat (4) tick();
        tests++;
        if (exp0.size() != 0 || beat_cnt0 !== CW'(mcnt0)) begin
            fails++;
            $display("FAIL bp_drain: pending=%0d c0=%0d required 0/%0d", exp0.size(), beat_cnt0, mcnt0);
        end
    endtask

    task automatic test_drop_and_disable();
        do_reset();
        burst_len = 8'd8;
        fill(0, 20); fill(1, 20);
        vld_en = 2'b11;
        tick();
        tick();
        tick();
        tests++;
        if (obs_srdy !== 2'b01 || mcnt0 != 2) begin
            fails++;
            $display("FAIL drop_first: rdy=%b beats=%0d required 01/2", obs_srdy, mcnt0);
        end
        vld_en = 2'b10;
        tick();
        tick();
        tests++;
        if (obs_srdy !== 2'b00) begin
            fails++;
            $display("FAIL drop_bubble: s_rdy=%b required 00", obs_srdy);
        end
        tick();
        tests++;
        if (obs_srdy !== 2'b10) begin
            fails++;
            $display("FAIL drop_ch1: s_rdy=%b required 10", obs_srdy);
        end
        tick();
        enable = 1'b0;
        tick();
        tick();
        tests++;
        if (obs_srdy !== 2'b00 || obs_busy !== 1'b1 || obs_valid !== 1'b1) begin
            fails++;
            $display("FAIL dis_drain: rdy=%b busy=%b v=%b required 00/1/1", obs_srdy, obs_busy, obs_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (obs_srdy !== 2'b00 || obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
                fails++;
                $display("FAIL dis_idle%0d: rdy=%b busy=%b v=%b required 00/0/0",
                         i, obs_srdy, obs_busy, obs_valid);
            end
        end
        enable = 1'b1;
        vld_en = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        do_reset();
        burst_len = 8'd0;
        fill(0, 17);
        vld_en = 2'b01;
        for (int i = 0; i < 60 && mcnt0 < 17; i++) tick();
        repeat (3) tick();
        tests++;
        if (mcnt0 != 17 || beat_cnt0 !== 4'd1) begin
            fails++;
            $display("FAIL wrap: beats=%0d c0=%0d required 17/1", mcnt0, beat_cnt0);
        end
    endtask

    task automatic test_random();
        do_reset();
        burst_len = 8'($urandom_range(1, 6));
        fill(0, 50); fill(1, 50);
        for (int i = 0; i < 1500; i++) begin
            vld_en[0] = ($urandom_range(0, 4) != 0);
            vld_en[1] = ($urandom_range(0, 4) != 0);
            m_tready  = ($urandom_range(0, 9) < 7);
            urgent[0] = ($urandom_range(0, 15) == 0);
            urgent[1] = ($urandom_range(0, 15) == 0);
            enable    = ($urandom_range(0, 19) != 0);
            if (src0.size() < 5) fill(0, 20);
            if (src1.size() < 5) fill(1, 20);
            tick();
        end
        enable = 1'b1; urgent = 2'b00; m_tready = 1'b1; vld_en = 2'b00;
        repeat (6) tick();
        tests++;
        if (exp0.size() != 0 || exp1.size() != 0 || obs_busy !== 1'b0) begin
            fails++;
            $display("FAIL rand_drain: pending=%0d/%0d busy=%b required 0/0/0",
                     exp0.size(), exp1.size(), obs_busy);
        end
        tests++;
        if (beat_cnt0 !== CW'(mcnt0) || beat_cnt1 !== CW'(mcnt1)) begin
            fails++;
            $display("FAIL rand_counts: got %0d/%0d required %0d/%0d",
                     beat_cnt0, beat_cnt1, CW'(mcnt0), CW'(mcnt1));
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_urgent();
        test_back_pressure();
        test_drop_and_disable();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
